cmsdk_mcu_mtx4x2_out_arb: RTL

CMSDK_MCU_MTX4X2_OUT_ARB -- requirements
Module: cmsdk_mcu_mtx4x2_out_arb

---
 rtl/cmsdk_mcu_mtx4x2_out_arb.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cmsdk_mcu_mtx4x2_out_arb.sv
// Output-port arbiter for the 4x2 AHB bus matrix: round-robin address-phase grant
// with fixed-length burst hold, undefined-length INCR hold and locked-sequence hold.
module cmsdk_mcu_mtx4x2_out_arb (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [3:0]  req_in,
  input  logic [7:0]  trans_in,
  input  logic [11:0] burst_in,
  input  logic [3:0]  mastlock_in,
  input  logic        HREADYM,
  output logic [1:0]  addr_in_port,
  output logic        no_port,
  output logic [3:0]  active_in,
  output logic [1:0]  data_in_port,
  output logic        data_valid
);

  // state   | meaning
  // NOPORT  | no port owns the address phase, output drives IDLE
  // SINGLE  | port granted, next acceptance is an arbitration point (unless INCR continues)
  // BURST   | fixed-length burst in progress, beat_cnt beats still to come
  // LOCK    | locked sequence, grant held until an unlocked transfer is accepted
  typedef enum logic [1:0] {ST_NOPORT, ST_SINGLE, ST_BURST, ST_LOCK} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_INCR   = 3'b001;

  state_t      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic        no_port_q, no_port_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  dport_q, dport_d;
  logic        dvalid_q, dvalid_d;

  logic [1:0]  trans_a [4];
  logic [2:0]  burst_a [4];
  logic [1:0]  g_trans;
  logic [2:0]  g_burst;
  logic        g_lock;
  logic        g_req;
  logic        g_nonseq;
  logic        incr_hold;
  logic [3:0]  load;
  logic        arb;
  logic        win_found;
  logic [1:0]  win;
  logic [1:0]  idx;

  function automatic logic [3:0] beat_load(input logic [2:0] b);
    case (b)
      3'b010, 3'b011: beat_load = 4'd3;
      3'b100, 3'b101: beat_load = 4'd7;
      3'b110, 3'b111: beat_load = 4'd15;
      default:        beat_load = 4'd0;
    endcase
  endfunction

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      trans_a[p] = trans_in[2*p +: 2];
      burst_a[p] = burst_in[3*p +: 3];
    end
    g_trans   = trans_a[addr_q];
    g_burst   = burst_a[addr_q];
    g_lock    = mastlock_in[addr_q];
    g_req     = req_in[addr_q];
    g_nonseq  = (g_trans == TR_NONSEQ);
    load      = beat_load(g_burst);
    // undefined-length INCR keeps the grant only while the port keeps streaming
    incr_hold = g_req && ((g_nonseq && g_burst == BU_INCR) ||
                          g_trans == TR_SEQ || g_trans == TR_BUSY);
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win       = last_q;
    idx       = last_q;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!win_found && req_in[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    no_port_d = no_port_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    dport_d   = dport_q;
    dvalid_d  = dvalid_q;
    arb       = 1'b0;
    if (HREADYM) begin
      dport_d  = addr_q;
      dvalid_d = !no_port_q && g_trans[1];
      case (state_q)
        ST_NOPORT: arb = 1'b1;
        ST_LOCK: begin
          if (!g_lock) arb = 1'b1;
        end
        ST_BURST: begin
          if (g_lock) begin
            state_d = ST_LOCK;
            cnt_d   = 4'd0;
          end else if (!g_req || g_trans == TR_IDLE || g_nonseq) begin
            arb = 1'b1;
          end else if (g_trans == TR_SEQ) begin
            if (cnt_q <= 4'd1) arb = 1'b1;
            else               cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          if (g_lock) begin
            state_d = ST_LOCK;
          end else if (g_req && g_nonseq && load != 4'd0) begin
            state_d = ST_BURST;
            cnt_d   = load;
          end else if (!incr_hold) begin
            arb = 1'b1;
          end
        end
      endcase
      if (arb) begin
        cnt_d = 4'd0;
        if (win_found) begin
          no_port_d = 1'b0;
          addr_d    = win;
          last_d    = win;
          state_d   = ST_SINGLE;
          // a terminating NONSEQ that wins its own port back starts the new burst now
          if (!no_port_q && win == addr_q && g_req && g_nonseq && load != 4'd0) begin
            state_d = ST_BURST;
            cnt_d   = load;
          end
        end else begin
          no_port_d = 1'b1;
          state_d   = ST_NOPORT;
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_NOPORT;
      addr_q    <= 2'd0;
      no_port_q <= 1'b1;
      last_q    <= 2'd3;
      cnt_q     <= 4'd0;
      dport_q   <= 2'd0;
      dvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      no_port_q <= no_port_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      dport_q   <= dport_d;
      dvalid_q  <= dvalid_d;
    end
  end

  assign addr_in_port = addr_q;
  assign no_port      = no_port_q;
  assign active_in    = no_port_q ? 4'b0000 : (4'b0001 << addr_q);
  assign data_in_port = dport_q;
  assign data_valid   = dvalid_q;

endmodule
